s2_apb_slave_mem: RTL

- APB slave endpoint on NoC slave port 2. It consumes the S2_PSEL/S2_PENABLE/S2_PWRITE/S2_PADDR/S2_PDATA/S2_PSTRB request bundle and drives S2_PRDATA/S2_PREADY/S2_PSLVERR back.
- Implements a word-addressed register/memory array with programmable wait states.
- Word 0 is a read-only ID register.
- Error response for out-of-range, misaligned, or read-only-write accesses.

---
 rtl/s2_apb_pkg.sv | 36 +++
 rtl/s2_apb_regfile.sv | 39 +++
 rtl/s2_apb_slave_mem.sv | 133 +++++++++++++
 3 files changed

// File: rtl/s2_apb_pkg.sv
// Shared types, widths and address decode for the slave-port-2 APB memory endpoint.
package s2_apb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              err;
    logic [ADDR_W-1:0] idx;
  } dec_t;

  // Flags out-of-window, misaligned and ID-register writes; idx is the untruncated word offset.
  // The upper window limit is computed one bit wider so a window touching 4 GiB cannot wrap.
  function automatic dec_t addr_decode(input logic [ADDR_W-1:0] paddr,
                                       input logic              pwrite,
                                       input logic [ADDR_W-1:0] base,
                                       input int unsigned       depth);
    dec_t              d;
    logic [ADDR_W:0]   limit;
    logic [ADDR_W-1:0] off;
    limit = {1'b0, base} + ((ADDR_W+1)'(depth) << 2);
    off   = paddr - base;
    d.idx = off >> 2;
    d.err = (paddr < base) || ({1'b0, paddr} >= limit) ||
            (paddr[1:0] != 2'b00) || (pwrite && (d.idx == '0));
    return d;
  endfunction

endpackage

// File: rtl/s2_apb_regfile.sv
// DEPTH x 32 word array with byte-strobed writes and a combinational read port.
// Word 0 is never stored: reads of it return the fixed ID value.
module s2_apb_regfile
  import s2_apb_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] ID_VALUE = 32'h5332_0001,
  localparam int         IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] strb_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear all words on reset; otherwise update only the strobed bytes of the addressed word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read mux with the ID register overlaid on word 0.
  always_comb begin
    rd_data_o = mem_q[rd_idx_i];
    if (rd_idx_i == '0) rd_data_o = ID_VALUE;
  end

endmodule

// File: rtl/s2_apb_slave_mem.sv
// APB slave on NoC port 2: word memory with programmable wait states and error responses.
//   state | meaning
//   IDLE  | waiting for a setup phase (PSEL=1, PENABLE=0)
//   WAIT  | inserting PREADY-low access cycles; PSEL drop aborts
//   RESP  | PREADY high for one cycle; writes commit on the edge leaving it
module s2_apb_slave_mem
  import s2_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h5332_0001
) (
  input  logic              ACLK,
  input  logic              ASW_RESET,
  input  logic              S2_PSEL,
  input  logic              S2_PENABLE,
  input  logic              S2_PWRITE,
  input  logic [ADDR_W-1:0] S2_PADDR,
  input  logic [DATA_W-1:0] S2_PDATA,
  input  logic [STRB_W-1:0] S2_PSTRB,
  output logic [DATA_W-1:0] S2_PRDATA,
  output logic              S2_PREADY,
  output logic              S2_PSLVERR
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q, pslverr_q;

  dec_t              dec;
  logic              src_err_d, src_wr_d, wr_en_d;
  logic [IDX_W-1:0]  rd_idx_d;
  logic [DATA_W-1:0] rd_data, rsp_rdata_d;

  assign dec = addr_decode(S2_PADDR, S2_PWRITE, BASE_ADDR, DEPTH);

  // Response source: live bus when going straight from setup to RESP, latched request otherwise.
  always_comb begin
    src_err_d = err_q;
    src_wr_d  = wr_q;
    rd_idx_d  = idx_q;
    if (state_q == IDLE) begin
      src_err_d = dec.err;
      src_wr_d  = S2_PWRITE;
      rd_idx_d  = IDX_W'(dec.idx);
    end
    rsp_rdata_d = (src_wr_d || src_err_d) ? '0 : rd_data;
  end

  assign wr_en_d = (state_q == RESP) && wr_q && !err_q;

  s2_apb_regfile #(
    .DEPTH    (DEPTH),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk_i     (ACLK),
    .rst_i     (ASW_RESET),
    .we_i      (wr_en_d),
    .wr_idx_i  (idx_q),
    .wdata_i   (wdata_q),
    .strb_i    (strb_q),
    .rd_idx_i  (rd_idx_d),
    .rd_data_o (rd_data)
  );

  // Transfer FSM with wait-state down-counter; response outputs are registered on entry to RESP.
  always_ff @(posedge ACLK) begin
    if (ASW_RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (S2_PSEL && !S2_PENABLE) begin
            wr_q    <= S2_PWRITE;
            err_q   <= dec.err;
            idx_q   <= IDX_W'(dec.idx);
            wdata_q <= S2_PDATA;
            strb_q  <= S2_PSTRB;
            if (WAIT_CYCLES == 0) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              prdata_q  <= rsp_rdata_d;
              pslverr_q <= src_err_d;
            end else begin
              cnt_q   <= CNT_LOAD;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!S2_PSEL) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q   <= RESP;
            pready_q  <= 1'b1;
            prdata_q  <= rsp_rdata_d;
            pslverr_q <= src_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S2_PRDATA  = prdata_q;
  assign S2_PREADY  = pready_q;
  assign S2_PSLVERR = pslverr_q;

endmodule
